// File: rtl/decode_queue.sv
// ---------------------------------------------------------------------------
// decode_queue
//   Instruction buffer between the fetch and decode stages of an RV32I
//   pipeline. It holds up to DEPTH {instr, pc} pairs in a circular buffer and
//   presents the head entry already split into its decode fields.
//
//   Optional feature macro: DECODE_IMM_GEN_EN
//     defined     -> out_imm is the sign-extended RV32I immediate chosen by
//                    the head opcode (I/S/B/U/J formats, 0 otherwise)
//     not defined -> out_imm is the raw instr[31:7] field, zero-extended
//
// Parameters
//   DEPTH  number of entries (power of two, >= 2)
//   PC_W   width of the carried PC
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   flush             synchronous discard of every entry (wins over push/pop)
//   in_valid/in_ready fetch-side handshake; in_ready = (count != DEPTH)
//   in_instr, in_pc   word offered by fetch
//   out_valid/out_ready decode-side handshake; out_valid = (count != 0)
//   out_pc, out_rs1, out_rs2, out_rd, out_opcode, out_funct3, out_funct7
//                     slices of the head entry
//   out_imm           immediate of the head entry (see macro above)
//   count             current occupancy
// ---------------------------------------------------------------------------
module decode_queue #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_instr,
    input  logic [PC_W-1:0]            in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [PC_W-1:0]            out_pc,
    output logic [4:0]                 out_rs1,
    output logic [4:0]                 out_rs2,
    output logic [4:0]                 out_rd,
    output logic [6:0]                 out_opcode,
    output logic [2:0]                 out_funct3,
    output logic [6:0]                 out_funct7,
    output logic [31:0]                out_imm,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]     instr_mem [DEPTH];
    logic [PC_W-1:0] pc_mem    [DEPTH];

    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW-1:0] wr_ptr_next;
    logic [AW-1:0] rd_ptr_next;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;

    logic push;
    logic pop;
    logic [31:0] head_instr;

    // in_ready depends only on the registered count, so a pop in the same
    // cycle never lets a push through while full.
    assign in_ready  = (count_reg != CW'(DEPTH));
    assign out_valid = (count_reg != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign count     = count_reg;

    // Storage entries are cleared by reset so that the head slices read zero
    // immediately after rst, with no gating on the output path.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    instr_mem[gi] <= '0;
                    pc_mem[gi]    <= '0;
                end else if (push && !flush && (wr_ptr_reg == AW'(gi))) begin
                    instr_mem[gi] <= in_instr;
                    pc_mem[gi]    <= in_pc;
                end
            end
        end
    endgenerate

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            // Pointers wrap through natural AW-bit overflow.
            if (push) begin
                wr_ptr_next = wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_next = count_reg + CW'(1);
                2'b01:   count_next = count_reg - CW'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Head decode: pure slices of registered storage.
    assign head_instr = instr_mem[rd_ptr_reg];
    assign out_pc     = pc_mem[rd_ptr_reg];
    assign out_rs1    = head_instr[19:15];
    assign out_rs2    = head_instr[24:20];
    assign out_rd     = head_instr[11:7];
    assign out_opcode = head_instr[6:0];
    assign out_funct3 = head_instr[14:12];
    assign out_funct7 = head_instr[31:25];

`ifdef DECODE_IMM_GEN_EN
    always_comb begin
        out_imm = '0;
        case (head_instr[6:0])
            7'b0000011, 7'b0010011, 7'b1100111:
                out_imm = {{20{head_instr[31]}}, head_instr[31:20]};
            7'b0100011:
                out_imm = {{20{head_instr[31]}}, head_instr[31:25], head_instr[11:7]};
            7'b1100011:
                out_imm = {{19{head_instr[31]}}, head_instr[31], head_instr[7],
                           head_instr[30:25], head_instr[11:8], 1'b0};
            7'b0110111, 7'b0010111:
                out_imm = {head_instr[31:12], 12'b0};
            7'b1101111:
                out_imm = {{11{head_instr[31]}}, head_instr[31], head_instr[19:12],
                           head_instr[20], head_instr[30:21], 1'b0};
            default:
                out_imm = '0;
        endcase
    end
`else
    assign out_imm = {7'b0, head_instr[31:7]};
`endif

endmodule

// File: tb/tb_decode_queue.sv
// ---------------------------------------------------------------------------
// tb_decode_queue
//   Self-checking bench for decode_queue (DEPTH=4, PC_W=32). A queue of
//   {pc, instr} pairs models the buffer; expected fields and immediates are
//   computed from the instruction word with shifts and masks.
//   Honours the DECODE_IMM_GEN_EN macro in the same way as the design.
// ---------------------------------------------------------------------------
module tb_decode_queue;

    localparam int DEPTH = 4;
    localparam int PC_W  = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [4:0]  out_rd;
    logic [6:0]  out_opcode;
    logic [2:0]  out_funct3;
    logic [6:0]  out_funct7;
    logic [31:0] out_imm;
    logic [2:0]  count;

    decode_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7(out_funct7),
        .out_imm(out_imm), .count(count)
    );

    always #5 clk = ~clk;

    logic [63:0] mq[$];
    int errors = 0;
    int checks = 0;

    wire [4:0]  dut_status = {out_valid, in_ready, count};
    wire [95:0] dut_head   = {out_pc, out_rs1, out_rs2, out_rd, out_opcode,
                              out_funct3, out_funct7, out_imm};

    function automatic logic [31:0] ref_imm(input logic [31:0] i);
`ifdef DECODE_IMM_GEN_EN
        logic [31:0] s;
        s = i[31] ? 32'hFFFF_FFFF : 32'h0;
        case (i & 32'h7F)
            32'h03, 32'h13, 32'h67: return (s << 12) | (i >> 20);
            32'h23:                 return (s << 12) | ((i >> 25) << 5) | ((i >> 7) & 32'h1F);
            32'h63:                 return (s << 12) | (((i >> 7) & 1) << 11) |
                                           (((i >> 25) & 32'h3F) << 5) | (((i >> 8) & 32'hF) << 1);
            32'h37, 32'h17:         return i & 32'hFFFF_F000;
            32'h6F:                 return (s << 20) | (((i >> 12) & 32'hFF) << 12) |
                                           (((i >> 20) & 1) << 11) | (((i >> 21) & 32'h3FF) << 1);
            default:                return 32'h0;
        endcase
`else
        return i >> 7;
`endif
    endfunction

    function automatic logic [4:0] exp_status();
        int n = mq.size();
        return {n != 0, n != DEPTH, 3'(n)};
    endfunction

    function automatic logic [95:0] exp_head();
        logic [31:0] i;
        logic [31:0] p;
        i = mq[0][31:0];
        p = mq[0][63:32];
        return {p, 5'((i >> 15) & 31), 5'((i >> 20) & 31), 5'((i >> 7) & 31),
                7'(i & 127), 3'((i >> 12) & 7), 7'(i >> 25), ref_imm(i)};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] ops [10];
        logic [31:0] w;
        ops = '{32'h03, 32'h13, 32'h67, 32'h23, 32'h63, 32'h37, 32'h17, 32'h6F, 32'h33, 32'h0F};
        w = $urandom;
        return (w & 32'hFFFF_FF80) | ops[$urandom_range(0, 9)];
    endfunction

    // One clock edge; the model follows the inputs driven before the edge.
    task automatic cycle();
        bit push;
        bit pop;
        push = in_valid && (mq.size() != DEPTH);
        pop  = out_ready && (mq.size() != 0);
        @(posedge clk);
        #1;
        if (rst || flush) begin
            mq.delete();
        end else begin
            if (pop)  void'(mq.pop_front());
            if (push) mq.push_back({in_pc, in_instr});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0;
        cycle(); cycle();
        #3 rst = 1'b0;
        checks++;
        if (dut_status !== 5'b01_000) begin
            errors++;
            $display("FAIL reset_status: got %b want 01000", dut_status);
        end
        checks++;
        if (dut_head !== 96'h0) begin
            errors++;
            $display("FAIL reset_fields: got %h want 0", dut_head);
        end
    endtask

    task automatic test_addi();
        logic [31:0] want_imm;
`ifdef DECODE_IMM_GEN_EN
        want_imm = 32'hFFFF_FFFF;
`else
        want_imm = 32'h01FF_E201;
`endif
        in_valid = 1'b1; in_instr = 32'hFFF1_0093; in_pc = 32'h100;
        cycle();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, out_rs1, out_rd, out_opcode, out_funct3, out_pc, out_imm} !==
            {1'b1, 5'd2, 5'd1, 7'h13, 3'd0, 32'h100, want_imm}) begin
            errors++;
            $display("FAIL addi_fields: got v=%0b rs1=%0d rd=%0d op=%h f3=%0d pc=%h imm=%h want 1 2 1 13 0 100 %h",
                     out_valid, out_rs1, out_rd, out_opcode, out_funct3, out_pc, out_imm, want_imm);
        end
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        checks++;
        if (dut_status !== exp_status()) begin
            errors++;
            $display("FAIL addi_drain: got %b want %b", dut_status, exp_status());
        end
    endtask

    task automatic test_full();
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; in_instr = rand_instr(); in_pc = 32'h200 + 4 * k;
            cycle();
        end
        in_valid = 1'b0;
        checks++;
        if (dut_status !== 5'b10_100) begin
            errors++;
            $display("FAIL full_status: got %b want 10100", dut_status);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (dut_head !== exp_head() || out_pc !== 32'h200 + 4 * k) begin
                errors++;
                $display("FAIL full_pop%0d: got %h want %h", k, dut_head, exp_head());
            end
            cycle();
        end
        out_ready = 1'b0;
        checks++;
        if (dut_status !== 5'b01_000) begin
            errors++;
            $display("FAIL full_empty: got %b want 01000", dut_status);
        end
    endtask

    task automatic test_push_pop();
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_instr = rand_instr(); in_pc = 32'h300 + 4 * k;
            out_ready = (k == 2);
            cycle();
        end
        in_valid = 1'b0; out_ready = 1'b0;
        checks++;
        if (count !== 3'd2 || out_pc !== 32'h304 || dut_head !== exp_head()) begin
            errors++;
            $display("FAIL push_pop: got count=%0d pc=%h want count=2 pc=304", count, out_pc);
        end
        out_ready = 1'b1;
        cycle(); cycle();
        out_ready = 1'b0;
    endtask

    task automatic test_stream();
        int sent = 0;
        int got = 0;
        int cyc = 0;
        while (got < 10 && cyc < 100) begin
            in_valid  = (sent < 10);
            in_instr  = 32'h0000_0013 | (sent << 7);
            in_pc     = 32'h400 + 4 * sent;
            out_ready = cyc[0] == 1'b0;
            if (out_valid) begin
                checks++;
                if (dut_head !== exp_head() || out_pc !== 32'h400 + 4 * got) begin
                    errors++;
                    $display("FAIL stream_word%0d: got %h want %h", got, dut_head, exp_head());
                end
            end
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) got++;
            cycle();
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        checks++;
        if (got != 10) begin
            errors++;
            $display("FAIL stream_timeout: got %0d words want 10", got);
        end
    endtask

    task automatic test_flush();
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_instr = rand_instr(); in_pc = 32'h500 + 4 * k;
            cycle();
        end
        flush = 1'b1; in_instr = 32'hDEAD_BEEF; in_pc = 32'hBAD;
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if (dut_status !== 5'b01_000) begin
            errors++;
            $display("FAIL flush_status: got %b want 01000", dut_status);
        end
        in_valid = 1'b1; in_instr = 32'h0020_8133; in_pc = 32'h600;
        cycle();
        in_valid = 1'b0;
        checks++;
        if (out_pc !== 32'h600 || dut_head !== exp_head()) begin
            errors++;
            $display("FAIL flush_refill: got pc=%h want 600", out_pc);
        end
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_instr = rand_instr(); in_pc = 32'h700 + 4 * k;
            cycle();
        end
        in_valid = 1'b0;
        #3 rst = 1'b1;
        #1;
        checks++;
        if (dut_status !== 5'b01_000 || dut_head !== 96'h0) begin
            errors++;
            $display("FAIL async_reset: got status=%b head=%h want 01000 and 0", dut_status, dut_head);
        end
        cycle();
        #3 rst = 1'b0;
    endtask

    task automatic test_branch();
        logic [31:0] want_imm;
`ifdef DECODE_IMM_GEN_EN
        want_imm = 32'hFFFF_FFFC;
`else
        want_imm = 32'h01FC_001D;
`endif
        in_valid = 1'b1; in_instr = 32'hFE00_0EE3; in_pc = 32'h800;
        cycle();
        in_valid = 1'b0;
        checks++;
        if (out_opcode !== 7'h63 || out_imm !== want_imm) begin
            errors++;
            $display("FAIL branch_imm: got op=%h imm=%h want 63 %h", out_opcode, out_imm, want_imm);
        end
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            in_valid  = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 2) != 0;
            flush     = $urandom_range(0, 39) == 0;
            in_instr  = rand_instr();
            in_pc     = $urandom;
            cycle();
            checks++;
            if (dut_status !== exp_status()) begin
                errors++;
                $display("FAIL random_status%0d: got %b want %b", k, dut_status, exp_status());
            end
            if (mq.size() != 0) begin
                checks++;
                if (dut_head !== exp_head()) begin
                    errors++;
                    $display("FAIL random_head%0d: got %h want %h", k, dut_head, exp_head());
                end
            end
        end
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_full();
        test_push_pop();
        test_stream();
        test_flush();
        test_async_reset();
        test_branch();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
